fpu_arbiter: RTL and testbench

FPU_ARBITER -- requirements
Module: fpu_arbiter

---
 rtl/fpu_pkg.sv | 26 ++
 rtl/fpu_arbiter_rr_arb2.sv | 15 +
 rtl/fpu_arbiter.sv | 157 +++++++++++++++
 tb/tb_fpu_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU arbiter: FSM state encoding, the team
// 32-bit float layout (sign, 6-bit exponent with bias 31, 25-bit mantissa) and status codes.
package fpu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_t;

   localparam int EXP_W = 6;
   localparam int MAN_W = 25;
   localparam int BIAS  = 31;

   localparam logic [3:0] STATUS_TIMEOUT = 4'b1000;

   // Builds a team-format float from sign, unbiased exponent and mantissa field.
   function automatic logic [31:0] fp_pack(input logic sign, input int exp_unb,
                                           input logic [MAN_W-1:0] man);
      logic [EXP_W-1:0] e;
      e = EXP_W'(exp_unb + BIAS);
      return {sign, e, man};
   endfunction

endpackage

// File: rtl/fpu_arbiter_rr_arb2.sv
// Two-way round-robin grant: with both requesters valid, the one not served last wins.
module rr_arb2 (
   input  logic [1:0] valid_i,
   input  logic       last_i,
   output logic [1:0] grant_o
);

   always_comb begin
      grant_o = valid_i;
      if (valid_i == 2'b11) begin
         grant_o = last_i ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/fpu_arbiter.sv
// Arbitrates two requesters onto one shared FPU and returns the result to the issuer.
// Optional WAIT-state watchdog enabled by defining FPU_ARB_TIMEOUT_EN.
module fpu_arbiter
   import fpu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req0_valid,
   input  logic        req1_valid,
   output logic        req0_ready,
   output logic        req1_ready,
   input  logic [31:0] req0_op_a,
   input  logic [31:0] req0_op_b,
   input  logic [31:0] req1_op_a,
   input  logic [31:0] req1_op_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic [3:0]  rsp_status,
   output logic        rsp_id,
   output logic        fpu_start,
   output logic [31:0] fpu_op_a,
   output logic [31:0] fpu_op_b,
   input  logic        fpu_done,
   input  logic [31:0] fpu_data,
   input  logic [3:0]  fpu_status,
   output logic        fpu_rst_n,
   output logic [1:0]  dbg_state_o
);

   // Handshakes: a transfer happens on a rising clock edge where valid and ready
   // are both high; ready never waits on a combinational path from the same valid
   // beyond the IDLE grant, and rsp_* hold steady while rsp_valid waits for rsp_ready.

   if (TIMEOUT_CYCLES < 1 || 1 + EXP_W + MAN_W != 32) begin : g_cfg_err
      $error("fpu_arbiter: invalid configuration");
   end

   arb_state_t  state_q, state_d;
   logic [31:0] op_a_q, op_b_q, rsp_data_q;
   logic [3:0]  rsp_status_q;
   logic        id_q, rr_last_q;
   logic [1:0]  grant;
   logic        accept, capture, timeout_hit, tmo_expired;

   rr_arb2 u_rr (
      .valid_i ({req1_valid, req0_valid}),
      .last_i  (rr_last_q),
      .grant_o (grant)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      accept      = 1'b0;
      capture     = 1'b0;
      timeout_hit = 1'b0;
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;
      fpu_start   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Gated by reset so both readies read low while reset is held.
            req0_ready = grant[0] & reset;
            req1_ready = grant[1] & reset;
            if ((req0_valid & req0_ready) | (req1_valid & req1_ready)) begin
               accept  = 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            fpu_start = 1'b1;
            state_d   = ST_WAIT;
         end
         ST_WAIT: begin
            if (fpu_done) begin
               capture = 1'b1;
               state_d = ST_RESP;
            end else if (tmo_expired) begin
               timeout_hit = 1'b1;
               state_d     = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // rr_last_q resets to 1 so the first contended grant goes to req0.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         op_a_q       <= '0;
         op_b_q       <= '0;
         id_q         <= 1'b0;
         rsp_data_q   <= '0;
         rsp_status_q <= '0;
         rr_last_q    <= 1'b1;
      end else begin
         if (accept) begin
            op_a_q <= grant[1] ? req1_op_a : req0_op_a;
            op_b_q <= grant[1] ? req1_op_b : req0_op_b;
            id_q   <= grant[1];
         end
         if (capture) begin
            rsp_data_q   <= fpu_data;
            rsp_status_q <= fpu_status;
         end
         if (timeout_hit) begin
            rsp_data_q   <= '0;
            rsp_status_q <= STATUS_TIMEOUT;
         end
         if (state_q == ST_RESP && rsp_ready) rr_last_q <= id_q;
      end
   end

`ifdef FPU_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] tmo_cnt_q;
   logic             fpu_rst_n_q;

   // Counts cycles spent in WAIT; fpu_rst_n drops for the cycle after expiry.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tmo_cnt_q   <= '0;
         fpu_rst_n_q <= 1'b1;
      end else begin
         fpu_rst_n_q <= ~timeout_hit;
         if (state_q == ST_WAIT) tmo_cnt_q <= tmo_cnt_q + 1'b1;
         else                    tmo_cnt_q <= '0;
      end
   end

   assign tmo_expired = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign fpu_rst_n   = fpu_rst_n_q;
`else
   assign tmo_expired = 1'b0;
   assign fpu_rst_n   = 1'b1;
`endif

   assign rsp_valid   = (state_q == ST_RESP);
   assign rsp_data    = rsp_data_q;
   assign rsp_status  = rsp_status_q;
   assign rsp_id      = id_q;
   assign fpu_op_a    = op_a_q;
   assign fpu_op_b    = op_b_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter: a table of single operations plus hand-written
// sequences for contention, back-pressure, reset in WAIT, early done and the watchdog.
module tb_fpu_arbiter;
   import fpu_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_op_a = '0, req0_op_b = '0, req1_op_a = '0, req1_op_b = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic [3:0]  rsp_status;
   logic        rsp_id;
   logic        fpu_start;
   logic [31:0] fpu_op_a, fpu_op_b;
   logic        fpu_done = 1'b0;
   logic [31:0] fpu_data = '0;
   logic [3:0]  fpu_status = '0;
   logic        fpu_rst_n;
   logic [1:0]  dbg_state;

   fpu_arbiter #(.TIMEOUT_CYCLES(8)) dut (
      .clock(clock), .reset(reset),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .req0_op_a(req0_op_a), .req0_op_b(req0_op_b),
      .req1_op_a(req1_op_a), .req1_op_b(req1_op_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_status(rsp_status), .rsp_id(rsp_id),
      .fpu_start(fpu_start), .fpu_op_a(fpu_op_a), .fpu_op_b(fpu_op_b),
      .fpu_done(fpu_done), .fpu_data(fpu_data), .fpu_status(fpu_status),
      .fpu_rst_n(fpu_rst_n), .dbg_state_o(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic apply_reset();
      @(posedge clock); #1 reset = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
   endtask

   // ---------------- monitors ----------------
   int start_cnt = 0, rst_low_cnt = 0, last_done_cyc = -1;
   always @(negedge clock) begin
      if (fpu_start) start_cnt++;
      if (!fpu_rst_n) rst_low_cnt++;
   end
   always @(posedge clock) begin
      if (fpu_done && dbg_state == ST_WAIT) last_done_cyc = cyc;
   end

   // ---------------- FPU model ----------------
   int          mdl_lat  = 0;   // 0: never answers
   logic        mdl_pass = 1'b0;
   logic [31:0] mdl_data = '0;
   logic [3:0]  mdl_stat = '0;
   initial begin
      forever begin
         @(negedge clock);
         if (fpu_start && mdl_lat > 0) begin
            repeat (mdl_lat) @(negedge clock);
            fpu_data   = mdl_pass ? fpu_op_a : mdl_data;
            fpu_status = mdl_stat;
            fpu_done   = 1'b1;
            @(negedge clock);
            fpu_done   = 1'b0;
         end
      end
   end

   // ---------------- scoreboard ----------------
   int n_pass = 0, n_total = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic sample();
      @(negedge clock); #1;
   endtask

   task automatic wait_accept(output int g, output bit got);
      got = 1'b0; g = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         sample();
         if (req0_valid && req0_ready) begin got = 1'b1; g = 0; end
         else if (req1_valid && req1_ready) begin got = 1'b1; g = 1; end
      end
      check("accept_seen", got, 1);
   endtask

   task automatic wait_rsp(output bit got);
      got = 1'b0;
      for (int k = 0; k < 60 && !got; k++) begin
         sample();
         if (rsp_valid) got = 1'b1;
      end
      check("rsp_seen", got, 1);
   endtask

   task automatic rsp_handshake();
      rsp_ready = 1'b1;
      @(posedge clock); #1 rsp_ready = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int          who;
      logic [31:0] op_a, op_b;
      int          lat;
      logic [31:0] res;
      logic [3:0]  stat;
      logic [31:0] exp_data;
      logic [3:0]  exp_stat;
      logic        exp_id;
   } vec_t;

   vec_t vecs[4];

   task automatic run_vec(input vec_t v, input int idx);
      int g; bit got; int acc_cyc, s0;
      mdl_lat = v.lat; mdl_data = v.res; mdl_stat = v.stat; mdl_pass = 1'b0;
      @(posedge clock); #1;
      if (v.who == 0) begin req0_valid = 1'b1; req0_op_a = v.op_a; req0_op_b = v.op_b; end
      else            begin req1_valid = 1'b1; req1_op_a = v.op_a; req1_op_b = v.op_b; end
      wait_accept(g, got);
      acc_cyc = cyc;
      s0 = start_cnt;
      exp_q.push_back(v.exp_data);
      @(posedge clock); #1 req0_valid = 1'b0; req1_valid = 1'b0;
      sample();
      check($sformatf("v%0d_start_at_T+1", idx), {31'b0, fpu_start}, 1);
      check($sformatf("v%0d_start_cycle", idx), cyc - acc_cyc, 1);
      check($sformatf("v%0d_fpu_op_a", idx), fpu_op_a, v.op_a);
      wait_rsp(got);
      check($sformatf("v%0d_rsp_after_done", idx), cyc - last_done_cyc, 1);
      check($sformatf("v%0d_rsp_data", idx), rsp_data, exp_q.pop_front());
      check($sformatf("v%0d_rsp_status", idx), rsp_status, v.exp_stat);
      check($sformatf("v%0d_rsp_id", idx), rsp_id, v.exp_id);
      check($sformatf("v%0d_one_start", idx), start_cnt - s0, 1);
      rsp_handshake();
      sample();
      check($sformatf("v%0d_back_idle", idx), dbg_state, ST_IDLE);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int g; bit got; int s0, bad;
      logic [31:0] sd; logic [3:0] ss; logic si;

      // 1.0 + 1.0 = 2.0; 2.0 + 1.0 = 3.0; -1.0 + 1.0 = 0; max + max overflows.
      vecs[0] = '{0, 32'h3E000000, 32'h3E000000, 5, 32'h40000000, 4'b0000, 32'h40000000, 4'b0000, 1'b0};
      vecs[1] = '{1, 32'h40000000, 32'h3E000000, 1, 32'h41000000, 4'b0000, 32'h41000000, 4'b0000, 1'b1};
      vecs[2] = '{0, 32'hBE000000, 32'h3E000000, 3, 32'h00000000, 4'b0010, 32'h00000000, 4'b0010, 1'b0};
      vecs[3] = '{1, 32'h7E000000, 32'h7E000000, 2, 32'h7E000000, 4'b0100, 32'h7E000000, 4'b0100, 1'b1};

      // Reset state
      repeat (2) @(posedge clock);
      sample();
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_fpu_start", fpu_start, 0);
      check("rst_fpu_rst_n", fpu_rst_n, 1);
      check("rst_state", dbg_state, ST_IDLE);
      check("fp_pack_one", fp_pack(1'b0, 0, '0), 32'h3E000000);
      @(posedge clock); #1 reset = 1'b1;

      for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

      // Contention: both valid throughout, grants alternate from req0 after reset
      apply_reset();
      mdl_pass = 1'b1; mdl_lat = 2; mdl_stat = 4'b0000;
      rsp_ready = 1'b1;
      req0_op_a = 32'hAAAA0000; req1_op_a = 32'hBBBB0001;
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_accept(g, got);
         check($sformatf("rr_grant%0d", i), g, i % 2);
         exp_q.push_back((i % 2) ? 32'hBBBB0001 : 32'hAAAA0000);
         wait_rsp(got);
         check($sformatf("rr_id%0d", i), rsp_id, i % 2);
         check($sformatf("rr_data%0d", i), rsp_data, exp_q.pop_front());
      end
      @(posedge clock); #1;
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;

      // Valid dropped before the grant edge: no transaction
      s0 = start_cnt;
      @(posedge clock); #1 req1_valid = 1'b1;
      @(negedge clock); #1 req1_valid = 1'b0;
      repeat (4) sample();
      check("drop_state_idle", dbg_state, ST_IDLE);
      check("drop_no_start", start_cnt - s0, 0);

      // Back-pressure: req1 stays valid while req0's response is stalled
      mdl_pass = 1'b1; mdl_lat = 2;
      req0_op_a = 32'hC0C0C0C0; req1_op_a = 32'hC1C1C1C1;
      @(posedge clock); #1 req0_valid = 1'b1; req1_valid = 1'b1;
      wait_accept(g, got);
      check("bp_grant_req0", g, 0);
      @(posedge clock); #1 req0_valid = 1'b0;
      wait_rsp(got);
      s0 = start_cnt;
      sd = rsp_data; ss = rsp_status; si = rsp_id;
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         sample();
         if (!rsp_valid || rsp_data !== sd || rsp_status !== ss || rsp_id !== si) bad++;
         if (req0_ready || req1_ready) bad++;
      end
      check("bp_stable", bad, 0);
      check("bp_no_restart", start_cnt - s0, 0);
      check("bp_data", sd, 32'hC0C0C0C0);
      mdl_lat = 0;
      rsp_handshake();
      sample();
      check("bp_next_grant_req1", req1_ready, 1);
      @(posedge clock); #1 req1_valid = 1'b0;
      repeat (3) sample();
      check("hung_in_wait", dbg_state, ST_WAIT);

      // Reset for two cycles during WAIT
      @(posedge clock); #1;
      req0_valid = 1'b1; req1_valid = 1'b1; reset = 1'b0;
      sample();
      check("rw_state", dbg_state, ST_IDLE);
      check("rw_rsp_valid", rsp_valid, 0);
      check("rw_rsp_data", rsp_data, 0);
      check("rw_rsp_status", rsp_status, 0);
      check("rw_rsp_id", rsp_id, 0);
      check("rw_fpu_start", fpu_start, 0);
      check("rw_fpu_op_a", fpu_op_a, 0);
      check("rw_fpu_op_b", fpu_op_b, 0);
      check("rw_ready0", req0_ready, 0);
      check("rw_ready1", req1_ready, 0);
      check("rw_fpu_rst_n", fpu_rst_n, 1);
      mdl_pass = 1'b0; mdl_lat = 2; mdl_data = 32'h55AA55AA; mdl_stat = 4'b0001;
      req0_op_a = 32'h3E000000;
      @(posedge clock); #1 reset = 1'b1;
      wait_accept(g, got);
      check("rw_next_grant_req0", g, 0);
      @(posedge clock); #1 req0_valid = 1'b0; req1_valid = 1'b0;
      wait_rsp(got);
      check("rw_after_id", rsp_id, 0);
      check("rw_after_data", rsp_data, 32'h55AA55AA);
      rsp_handshake();

      // fpu_done during ISSUE is ignored; the later one in WAIT is captured
      mdl_lat = 0;
      @(posedge clock); #1 req1_valid = 1'b1;
      wait_accept(g, got);
      @(posedge clock); #1 req1_valid = 1'b0;
      sample();
      check("ed_in_issue", dbg_state, ST_ISSUE);
      fpu_done = 1'b1; fpu_data = 32'hDEAD0000; fpu_status = 4'hF;
      sample();
      fpu_done = 1'b0;
      sample();
      check("ed_ignored_state", dbg_state, ST_WAIT);
      check("ed_ignored_valid", rsp_valid, 0);
      fpu_done = 1'b1; fpu_data = 32'h12345678; fpu_status = 4'b0101;
      sample();
      fpu_done = 1'b0;
      check("ed_rsp_valid", rsp_valid, 1);
      check("ed_rsp_data", rsp_data, 32'h12345678);
      check("ed_rsp_status", rsp_status, 4'b0101);
      rsp_handshake();

      // FPU never answers
      mdl_lat = 0;
      @(posedge clock); #1 req0_valid = 1'b1;
      wait_accept(g, got);
      @(posedge clock); #1 req0_valid = 1'b0;
`ifdef FPU_ARB_TIMEOUT_EN
      s0 = rst_low_cnt;
      wait_rsp(got);
      check("to_status", rsp_status, STATUS_TIMEOUT);
      check("to_data", rsp_data, 0);
      check("to_rst_pulse_low", fpu_rst_n, 0);
      sample();
      check("to_rst_back_high", fpu_rst_n, 1);
      check("to_rst_one_cycle", rst_low_cnt - s0, 1);
      rsp_handshake();
`else
      repeat (100) sample();
      check("nt_still_wait", dbg_state, ST_WAIT);
      check("nt_no_rsp", rsp_valid, 0);
      check("nt_rst_n_never_low", rst_low_cnt, 0);
      apply_reset();
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
